// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage load/store unit.
// Control bundle, FSM states and access-size codes.
package mem_pkg;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic [1:0] size;
    logic       sign;
  } mem_ctrl_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

endpackage

// File: rtl/mem_lsu_if.sv
// Pipeline request/response and data-memory port bundle.
// slave = the LSU, master = pipeline plus memory.
interface mem_lsu_if
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = 8192,
  localparam int AW = $clog2(MEM_WORDS)
);
  logic            i_req_valid;
  logic            o_req_ready;
  logic [31:0]     i_addr;
  logic [31:0]     i_wdata;
  mem_ctrl_t       i_ctrl;
  logic            o_resp_valid;
  logic [31:0]     o_rdata;
  logic            o_resp_err;
  logic            o_mem_en;
  logic [3:0]      o_mem_we;
  logic [AW-1:0]   o_mem_addr;
  logic [31:0]     o_mem_wdata;
  logic [31:0]     i_mem_rdata;

  modport slave (
    input  i_req_valid, i_addr, i_wdata, i_ctrl,
    input  i_mem_rdata,
    output o_req_ready, o_resp_valid, o_rdata,
    output o_resp_err, o_mem_en, o_mem_we,
    output o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_req_valid, i_addr, i_wdata, i_ctrl,
    output i_mem_rdata,
    input  o_req_ready, o_resp_valid, o_rdata,
    input  o_resp_err, o_mem_en, o_mem_we,
    input  o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Byte-lane steering for the LSU: store lanes/data
// across two words and load extract/extend.
module mem_lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [63:0] d64,
  output logic [7:0]  be64,
  output logic        split,
  output logic [63:0] wd64,
  output logic [31:0] rdata
);

  logic [7:0]  mask;
  logic [63:0] r64;
  logic [5:0]  sh;

  assign sh    = {1'b0, off, 3'b000};
  assign be64  = mask << off;
  assign split = |be64[7:4];
  assign wd64  = {32'b0, wdata} << sh;
  assign r64   = d64 >> sh;

  // Lane mask for the access width
  always_comb begin
    mask = 8'h00;
    unique case (size)
      SZ_BYTE: mask = 8'h01;
      SZ_HALF: mask = 8'h03;
      SZ_WORD: mask = 8'h0f;
      default: mask = 8'h00;
    endcase
  end

  // Keep the low bytes of the shifted word and extend
  always_comb begin
    rdata = 32'b0;
    unique case (size)
      SZ_BYTE: rdata = sign ? {24'b0, r64[7:0]}
                            : {{24{r64[7]}}, r64[7:0]};
      SZ_HALF: rdata = sign ? {16'b0, r64[15:0]}
                            : {{16{r64[15]}}, r64[15:0]};
      SZ_WORD: rdata = r64[31:0];
      default: rdata = 32'b0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one access at a time,
// split into two word beats when it crosses a word.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = 8192,
  localparam int AW = $clog2(MEM_WORDS)
)(
  input  logic      i_clk,
  input  logic      i_reset,
  mem_lsu_if.slave  bus
);

  lsu_state_t    state, nxt;
  logic [AW-1:0] idx_q, idx_nxt;
  logic [1:0]    off_q, size_q;
  logic          sign_q, store_q, err_q;
  logic [31:0]   wdata_q, lo_q;
  logic          accept, active;
  logic [7:0]    be64;
  logic          split;
  logic [63:0]   wd64, d64;
  logic [31:0]   ld_data;
  logic          unused_addr;

  assign unused_addr = ^{bus.i_addr[31:AW+2]};
  assign accept = bus.i_req_valid && bus.o_req_ready;
  assign active = bus.i_ctrl.memRead
               || bus.i_ctrl.memWrite;
  assign idx_nxt = (idx_q == AW'(MEM_WORDS - 1))
                 ? '0 : idx_q + 1'b1;
  assign d64 = split ? {bus.i_mem_rdata, lo_q}
                     : {32'b0, bus.i_mem_rdata};

  mem_lsu_align u_align (
    .off   (off_q),
    .size  (size_q),
    .sign  (sign_q),
    .wdata (wdata_q),
    .d64   (d64),
    .be64  (be64),
    .split (split),
    .wd64  (wd64),
    .rdata (ld_data)
  );

  // State register and request latches
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      lo_q    <= '0;
    end else begin
      state <= nxt;
      if (accept && active) begin
        idx_q   <= bus.i_addr[AW+1:2];
        off_q   <= bus.i_addr[1:0];
        size_q  <= bus.i_ctrl.size;
        sign_q  <= bus.i_ctrl.sign;
        store_q <= bus.i_ctrl.memWrite;
        err_q   <= bus.i_ctrl.size == SZ_ILL;
        wdata_q <= bus.i_wdata;
      end
      if (state == BEAT1) lo_q <= bus.i_mem_rdata;
    end
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept && active)
          nxt = (bus.i_ctrl.size == SZ_ILL)
              ? DONE : BEAT0;
      end
      BEAT0:   nxt = split ? BEAT1 : DONE;
      BEAT1:   nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Memory port and response outputs; reset blocks
  // any beat or response in the reset cycle itself
  always_comb begin
    bus.o_req_ready  = state == IDLE;
    bus.o_resp_valid = 1'b0;
    bus.o_resp_err   = 1'b0;
    bus.o_rdata      = '0;
    bus.o_mem_en     = 1'b0;
    bus.o_mem_we     = '0;
    bus.o_mem_addr   = '0;
    bus.o_mem_wdata  = '0;
    if (!i_reset) begin
      unique case (state)
        BEAT0: begin
          bus.o_mem_en   = 1'b1;
          bus.o_mem_addr = idx_q;
          if (store_q) begin
            bus.o_mem_we    = be64[3:0];
            bus.o_mem_wdata = wd64[31:0];
          end
        end
        BEAT1: begin
          bus.o_mem_en   = 1'b1;
          bus.o_mem_addr = idx_nxt;
          if (store_q) begin
            bus.o_mem_we    = be64[7:4];
            bus.o_mem_wdata = wd64[63:32];
          end
        end
        DONE: begin
          bus.o_resp_valid = 1'b1;
          bus.o_resp_err   = err_q;
          if (!err_q && !store_q)
            bus.o_rdata = ld_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a behavioural
// single-port word memory (1-cycle registered read).
module tb_mem_lsu;
  import mem_pkg::*;

  localparam int MW = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   nresp = 0;
  logic [31:0] mem [MW];
  logic [31:0] mem_rd = '0;

  mem_lsu_if #(.MEM_WORDS(MW)) bus ();

  mem_lsu #(.MEM_WORDS(MW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.i_mem_rdata = mem_rd;

  // Memory model with preload and byte-lane writes
  always @(posedge clk) begin
    if (preload) begin
      mem[32'h40]   <= 32'h88776655;
      mem[32'h41]   <= 32'hCCBBAA99;
      mem[32'h42]   <= 32'h0BADF00D;
      mem[MW-1]     <= 32'h11223344;
      mem[0]        <= 32'hA1B2C3D4;
    end else if (bus.o_mem_en) begin
      mem_rd <= mem[bus.o_mem_addr];
      for (int k = 0; k < 4; k++)
        if (bus.o_mem_we[k])
          mem[bus.o_mem_addr][8*k +: 8]
            <= bus.o_mem_wdata[8*k +: 8];
    end
  end

  // Count response pulses
  always @(posedge clk)
    if (bus.o_resp_valid) nresp <= nresp + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, return in the BEAT0 cycle
  task automatic req(input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic rd, wr,
                     input logic [1:0] sz,
                     input logic sg);
    bus.i_req_valid      = 1'b1;
    bus.i_addr           = a;
    bus.i_wdata          = wd;
    bus.i_ctrl.memRead   = rd;
    bus.i_ctrl.memWrite  = wr;
    bus.i_ctrl.size      = sz;
    bus.i_ctrl.sign      = sg;
    tick();
    bus.i_req_valid = 1'b0;
    bus.i_addr      = '0;
    bus.i_wdata     = '0;
    bus.i_ctrl      = '0;
  endtask

  initial begin
    int n0;
    bus.i_req_valid = 1'b0;
    bus.i_addr      = '0;
    bus.i_wdata     = '0;
    bus.i_ctrl      = '0;
    tick();
    tick();
    preload = 1'b0;
    rst     = 1'b0;

    chk("rst_ready", 32'(bus.o_req_ready), 32'd1);
    chk("rst_rv",    32'(bus.o_resp_valid), 32'd0);
    chk("rst_err",   32'(bus.o_resp_err), 32'd0);
    chk("rst_en",    32'(bus.o_mem_en), 32'd0);
    chk("rst_we",    32'(bus.o_mem_we), 32'd0);
    chk("rst_addr",  32'(bus.o_mem_addr), 32'd0);
    chk("rst_wd",    bus.o_mem_wdata, 32'd0);
    chk("rst_rd",    bus.o_rdata, 32'd0);

    // LW 0x100: aligned, one beat
    req(32'h100, 0, 1, 0, SZ_WORD, 0);
    chk("lw_en",   32'(bus.o_mem_en), 32'd1);
    chk("lw_addr", 32'(bus.o_mem_addr), 32'h40);
    chk("lw_we",   32'(bus.o_mem_we), 32'd0);
    chk("lw_rdy0", 32'(bus.o_req_ready), 32'd0);
    tick();
    chk("lw_rv",   32'(bus.o_resp_valid), 32'd1);
    chk("lw_data", bus.o_rdata, 32'h88776655);
    chk("lw_en2",  32'(bus.o_mem_en), 32'd0);
    tick();
    chk("lw_rdy1", 32'(bus.o_req_ready), 32'd1);
    chk("lw_rv0",  32'(bus.o_resp_valid), 32'd0);

    // LH 0x103 sign-extend: split
    req(32'h103, 0, 1, 0, SZ_HALF, 0);
    chk("lh_a0", 32'(bus.o_mem_addr), 32'h40);
    tick();
    chk("lh_a1", 32'(bus.o_mem_addr), 32'h41);
    chk("lh_en1", 32'(bus.o_mem_en), 32'd1);
    chk("lh_rv_early", 32'(bus.o_resp_valid), 32'd0);
    tick();
    chk("lh_rv", 32'(bus.o_resp_valid), 32'd1);
    chk("lh_s", bus.o_rdata, 32'hFFFF9988);
    tick();

    // LHU 0x103
    req(32'h103, 0, 1, 0, SZ_HALF, 1);
    tick();
    tick();
    chk("lhu", bus.o_rdata, 32'h00009988);
    tick();

    // LB 0x103 sign-extend, aligned
    req(32'h103, 0, 1, 0, SZ_BYTE, 0);
    tick();
    chk("lb_s", bus.o_rdata, 32'hFFFFFF88);
    tick();

    // SW 0x102: split store
    req(32'h102, 32'hDEADBEEF, 0, 1, SZ_WORD, 0);
    chk("sw_we0", 32'(bus.o_mem_we), 32'b1100);
    chk("sw_wd0", bus.o_mem_wdata, 32'hBEEF0000);
    chk("sw_a0",  32'(bus.o_mem_addr), 32'h40);
    tick();
    chk("sw_we1", 32'(bus.o_mem_we), 32'b0011);
    chk("sw_wd1", bus.o_mem_wdata, 32'h0000DEAD);
    chk("sw_a1",  32'(bus.o_mem_addr), 32'h41);
    tick();
    chk("sw_rv", 32'(bus.o_resp_valid), 32'd1);
    chk("sw_rd", bus.o_rdata, 32'd0);
    chk("sw_err", 32'(bus.o_resp_err), 32'd0);
    tick();
    chk("sw_m40", mem[32'h40], 32'hBEEF6655);
    chk("sw_m41", mem[32'h41], 32'hCCBBDEAD);

    // LW 0x7FFE: wraps from last word to word 0
    req(32'h7FFE, 0, 1, 0, SZ_WORD, 0);
    chk("wr_a0", 32'(bus.o_mem_addr), 32'd8191);
    tick();
    chk("wr_a1", 32'(bus.o_mem_addr), 32'd0);
    tick();
    chk("wr_data", bus.o_rdata, 32'hC3D41122);
    tick();

    // Illegal size
    req(32'h100, 0, 1, 0, SZ_ILL, 0);
    chk("ill_rv",  32'(bus.o_resp_valid), 32'd1);
    chk("ill_err", 32'(bus.o_resp_err), 32'd1);
    chk("ill_rd",  bus.o_rdata, 32'd0);
    chk("ill_en",  32'(bus.o_mem_en), 32'd0);
    tick();
    chk("ill_rdy", 32'(bus.o_req_ready), 32'd1);
    chk("ill_en2", 32'(bus.o_mem_en), 32'd0);

    // Neither read nor write: consumed silently
    n0 = nresp;
    req(32'h100, 0, 0, 0, SZ_WORD, 0);
    chk("nop_rdy", 32'(bus.o_req_ready), 32'd1);
    chk("nop_en",  32'(bus.o_mem_en), 32'd0);
    tick();
    tick();
    chk("nop_resp", 32'(nresp), 32'(n0));

    // Reset in BEAT1 of a split store at 0x106
    n0 = nresp;
    req(32'h106, 32'h12345678, 0, 1, SZ_WORD, 0);
    chk("rs_we0", 32'(bus.o_mem_we), 32'b1100);
    tick();
    rst = 1'b1;
    #1;
    chk("rs_en", 32'(bus.o_mem_en), 32'd0);
    tick();
    rst = 1'b0;
    chk("rs_rdy", 32'(bus.o_req_ready), 32'd1);
    chk("rs_rv", 32'(bus.o_resp_valid), 32'd0);
    tick();
    tick();
    chk("rs_resp", 32'(nresp), 32'(n0));
    chk("rs_m41", mem[32'h41], 32'h5678DEAD);
    chk("rs_m42", mem[32'h42], 32'h0BADF00D);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
